// File: rtl/future_pkg.sv
// Shared constants, FSM state type and S-box reference table for the FUTURE round datapath.
package future_pkg;

  localparam int NIB   = 16;
  localparam int DW    = 64;
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // Reference copy of the cell mapping, indexed by the input nibble value.
  localparam logic [3:0] SBOX [16] = '{
    4'h1, 4'h3, 4'h0, 4'h2, 4'h7, 4'hE, 4'h4, 4'hD,
    4'h9, 4'hA, 4'hC, 4'h6, 4'hF, 4'h5, 4'h8, 4'hB
  };

endpackage

// File: rtl/sb.sv
// FUTURE 4-bit S-box cell; x0/y0 are the nibble LSBs.
module sb (
  input  logic x0,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3
);

  logic [3:0] w_x;
  logic [3:0] w_y;

  assign w_x = {x3, x2, x1, x0};

  always_comb begin
    w_y = 4'h0;
    case (w_x)
      4'h0: w_y = 4'h1;
      4'h1: w_y = 4'h3;
      4'h2: w_y = 4'h0;
      4'h3: w_y = 4'h2;
      4'h4: w_y = 4'h7;
      4'h5: w_y = 4'hE;
      4'h6: w_y = 4'h4;
      4'h7: w_y = 4'hD;
      4'h8: w_y = 4'h9;
      4'h9: w_y = 4'hA;
      4'hA: w_y = 4'hC;
      4'hB: w_y = 4'h6;
      4'hC: w_y = 4'hF;
      4'hD: w_y = 4'h5;
      4'hE: w_y = 4'h8;
      4'hF: w_y = 4'hB;
      default: w_y = 4'h0;
    endcase
  end

  assign {y3, y2, y1, y0} = w_y;

endmodule

// File: rtl/sbox_layer_seq.sv
// Serial S-box layer: one shared cell substitutes the 16 state nibbles over 16 cycles,
// with valid/ready handshakes on both sides.
module sbox_layer_seq
  import future_pkg::*;
#(
  parameter int NIB = 16,
  parameter int DW  = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic [3:0]    nib_idx
);

  fsm_t             r_fsm;
  logic [NIB_W-1:0] r_nib_idx;
  logic [DW-1:0]    r_data;
  logic [3:0]       r_result [NIB];

  logic [3:0]       w_nib [NIB];
  logic [3:0]       w_nib_in;
  logic [3:0]       w_nib_out;
  logic [NIB-1:0]   w_wr_en;

  genvar gi;
  generate
    for (gi = 0; gi < NIB; gi++) begin : g_nib
      assign w_nib[gi]            = r_data[4*gi +: 4];
      assign w_wr_en[gi]          = (r_fsm == RUN) && !clr && (r_nib_idx == NIB_W'(gi));
      assign out_data[4*gi +: 4]  = r_result[gi];

      // Unwritten nibbles keep the previous block's value; harmless since out_valid is low.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_result[gi] <= 4'h0;
        end else if (w_wr_en[gi]) begin
          r_result[gi] <= w_nib_out;
        end
      end
    end
  endgenerate

  assign w_nib_in = w_nib[r_nib_idx];

  sb u_sb (
    .x0 (w_nib_in[0]),
    .x1 (w_nib_in[1]),
    .x2 (w_nib_in[2]),
    .x3 (w_nib_in[3]),
    .y0 (w_nib_out[0]),
    .y1 (w_nib_out[1]),
    .y2 (w_nib_out[2]),
    .y3 (w_nib_out[3])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm     <= IDLE;
      r_nib_idx <= '0;
      r_data    <= '0;
    end else if (clr) begin
      r_fsm     <= IDLE;
      r_nib_idx <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_data    <= in_data;
            r_nib_idx <= '0;
            r_fsm     <= RUN;
          end
        end
        RUN: begin
          if (r_nib_idx == NIB_W'(NIB - 1)) begin
            r_nib_idx <= '0;
            r_fsm     <= DONE;
          end else begin
            r_nib_idx <= r_nib_idx + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_fsm <= IDLE;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_fsm == IDLE);
  assign out_valid = (r_fsm == DONE);
  assign busy      = (r_fsm == RUN) || (r_fsm == DONE);
  assign nib_idx   = r_nib_idx;

endmodule

// File: tb/tb_sbox_layer_seq.sv
// Directed-vector bench for sbox_layer_seq: reset, latency, trace, backpressure, back-to-back, clr, async reset.
module tb_sbox_layer_seq;
  import future_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;
  logic [3:0]  nib_idx;

  int n_checks = 0;
  int n_pass   = 0;

  sbox_layer_seq #(.NIB(16), .DW(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .nib_idx   (nib_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a block and return after the edge that accepts it (bounded).
  task automatic accept(input logic [63:0] d, output bit ok);
    bit rdy;
    ok       = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rdy = in_ready;
      tick();
      if (rdy && busy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Edges from the acceptance edge until out_valid is seen; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #3;
    n_checks++;
    if ({in_ready, out_valid, busy, nib_idx} !== {1'b1, 1'b0, 1'b0, 4'h0})
      $display("FAIL reset_ctrl got rdy=%b vld=%b busy=%b idx=%0d want 1 0 0 0",
               in_ready, out_valid, busy, nib_idx);
    else n_pass++;
    n_checks++;
    if (out_data !== 64'h0) $display("FAIL reset_data got %h want 0", out_data);
    else n_pass++;
    #9 rst_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_zero_block();
    bit ok; int lat;
    out_ready = 1'b1;
    accept(64'h0, ok);
    n_checks++;
    if (!ok || in_ready !== 1'b0) $display("FAIL zero_accept ok=%b in_ready=%b want ok=1 in_ready=0", ok, in_ready);
    else n_pass++;
    wait_valid(lat);
    n_checks++;
    if (lat != 16) $display("FAIL zero_latency got %0d want 16", lat);
    else n_pass++;
    n_checks++;
    if (out_data !== 64'h1111111111111111) $display("FAIL zero_data got %h want 1111111111111111", out_data);
    else n_pass++;
    tick();
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL zero_idle got rdy=%b vld=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
    else n_pass++;
    $display("test_zero_block lat=%0d data=%h", lat, out_data);
  endtask

  task automatic test_nibble_trace();
    bit ok; bit trace_ok; bit tab_ok;
    logic [63:0] res;
    out_ready = 1'b1;
    accept(64'hFEDCBA9876543210, ok);
    trace_ok = ok && (nib_idx == 4'd0);
    for (int k = 1; k < 16; k++) begin
      tick();
      if (nib_idx != 4'(k) || out_valid) trace_ok = 1'b0;
    end
    tick();
    n_checks++;
    if (!trace_ok || !out_valid || nib_idx !== 4'd0)
      $display("FAIL trace_idx trace_ok=%b vld=%b idx=%0d want 1 1 0", trace_ok, out_valid, nib_idx);
    else n_pass++;
    res = out_data;
    n_checks++;
    if (res !== 64'hB85F6CA9D4E72031) $display("FAIL trace_data got %h want B85F6CA9D4E72031", res);
    else n_pass++;
    tab_ok = 1'b1;
    for (int i = 0; i < 16; i++)
      if (res[4*i +: 4] !== SBOX[i]) tab_ok = 1'b0;
    n_checks++;
    if (!tab_ok) $display("FAIL trace_table got %h against package table", res);
    else n_pass++;
    tick();
    $display("test_nibble_trace data=%h", res);
  endtask

  task automatic test_backpressure();
    bit ok; bit hold_ok; int lat;
    logic [63:0] held;
    out_ready = 1'b0;
    accept(64'h0123456789ABCDEF, ok);
    wait_valid(lat);
    n_checks++;
    if (!ok || lat != 16 || out_data !== 64'h13027E4D9AC6F58B)
      $display("FAIL bp_first ok=%b lat=%0d data=%h want 1 16 13027E4D9AC6F58B", ok, lat, out_data);
    else n_pass++;
    held = out_data;
    in_data  = 64'hAAAAAAAAAAAAAAAA;
    in_valid = 1'b1;
    hold_ok  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (!out_valid || out_data !== held || in_ready) hold_ok = 1'b0;
    end
    n_checks++;
    if (!hold_ok) $display("FAIL bp_hold vld=%b data=%h rdy=%b want 1 %h 0", out_valid, out_data, in_ready, held);
    else n_pass++;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL bp_handshake got rdy=%b vld=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({in_ready, busy} !== 2'b01) $display("FAIL bp_accept2 got rdy=%b busy=%b want 0 1", in_ready, busy);
    else n_pass++;
    wait_valid(lat);
    n_checks++;
    if (lat != 16 || out_data !== 64'hCCCCCCCCCCCCCCCC)
      $display("FAIL bp_second lat=%0d data=%h want 16 CCCCCCCCCCCCCCCC", lat, out_data);
    else n_pass++;
    tick();
    $display("test_backpressure held=%h", held);
  endtask

  task automatic test_back_to_back();
    bit rdy; int acc; int lat;
    logic [63:0] res1;
    out_ready = 1'b1;
    in_data   = 64'h1111111111111111;
    in_valid  = 1'b1;
    tick();
    in_data = 64'h00000000FFFFFFFF;
    acc  = -1;
    res1 = '0;
    for (int k = 1; k <= 30; k++) begin
      rdy = in_ready;
      tick();
      if (out_valid) res1 = out_data;
      if (rdy && !in_ready) begin
        acc = k;
        break;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (acc != 18) $display("FAIL b2b_spacing got %0d want 18", acc);
    else n_pass++;
    n_checks++;
    if (res1 !== 64'h3333333333333333) $display("FAIL b2b_first got %h want 3333333333333333", res1);
    else n_pass++;
    wait_valid(lat);
    n_checks++;
    if (lat != 16 || out_data !== 64'h11111111BBBBBBBB)
      $display("FAIL b2b_second lat=%0d data=%h want 16 11111111BBBBBBBB", lat, out_data);
    else n_pass++;
    tick();
    $display("test_back_to_back spacing=%0d", acc);
  endtask

  task automatic test_clr();
    bit ok; bit quiet; int lat;
    out_ready = 1'b1;
    accept(64'h5555555555555555, ok);
    for (int k = 0; k < 7; k++) tick();
    n_checks++;
    if (!ok || nib_idx !== 4'd7) $display("FAIL clr_setup ok=%b idx=%0d want 1 7", ok, nib_idx);
    else n_pass++;
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 64'h9999999999999999;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if ({in_ready, busy, out_valid, nib_idx} !== {1'b1, 1'b0, 1'b0, 4'h0})
      $display("FAIL clr_abort got rdy=%b busy=%b vld=%b idx=%0d want 1 0 0 0", in_ready, busy, out_valid, nib_idx);
    else n_pass++;
    quiet = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid || busy) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) $display("FAIL clr_quiet got vld=%b busy=%b want 0 0", out_valid, busy);
    else n_pass++;
    accept(64'h7777777777777777, ok);
    wait_valid(lat);
    n_checks++;
    if (!ok || lat != 16 || out_data !== 64'hDDDDDDDDDDDDDDDD)
      $display("FAIL clr_next ok=%b lat=%0d data=%h want 1 16 DDDDDDDDDDDDDDDD", ok, lat, out_data);
    else n_pass++;
    tick();
    $display("test_clr next_lat=%0d", lat);
  endtask

  task automatic test_async_reset();
    bit ok; int lat;
    out_ready = 1'b1;
    accept(64'h89ABCDEF01234567, ok);
    for (int k = 0; k < 5; k++) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, nib_idx} !== {1'b1, 1'b0, 1'b0, 4'h0} || out_data !== 64'h0)
      $display("FAIL arst_outputs got rdy=%b vld=%b busy=%b idx=%0d data=%h want 1 0 0 0 0",
               in_ready, out_valid, busy, nib_idx, out_data);
    else n_pass++;
    #2 rst_n = 1'b1;
    tick();
    accept(64'h0123456789ABCDEF, ok);
    wait_valid(lat);
    n_checks++;
    if (!ok || lat != 16 || out_data !== 64'h13027E4D9AC6F58B)
      $display("FAIL arst_fresh ok=%b lat=%0d data=%h want 1 16 13027E4D9AC6F58B", ok, lat, out_data);
    else n_pass++;
    tick();
    $display("test_async_reset fresh_lat=%0d", lat);
  endtask

  initial begin
    test_reset();
    test_zero_block();
    test_nibble_trace();
    test_backpressure();
    test_back_to_back();
    test_clr();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
